// File: rtl/band_envelope.sv
// Five-band envelope follower: rectifies each band sample and smooths it with a
// per-band leaky integrator, using one shared arithmetic unit stepped by a small FSM.
module band_envelope #(
    parameter int SHIFT = 4,
    parameter int FRAC  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_ready,
    input  logic [7:0] band0,
    input  logic [7:0] band1,
    input  logic [7:0] band2,
    input  logic [7:0] band3,
    input  logic [7:0] band4,
    output logic [7:0] env0,
    output logic [7:0] env1,
    output logic [7:0] env2,
    output logic [7:0] env3,
    output logic [7:0] env4,
    output logic       env_ready,
    output logic       overrun,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        pending;
    logic [2:0]  idx;
    logic [7:0]  shadow [5];
    logic [14:0] acc    [5];

    logic        busy;
    logic        accept;
    logic [7:0]  cur_x;
    logic [7:0]  neg_x;
    logic [6:0]  mag;
    logic [14:0] acc_cur;
    logic [14:0] acc_upd;

    // Handshake: sample_ready is a valid-only strobe with no backpressure. A strobe is
    // taken only when the block is idle with nothing pending; any strobe seen while a
    // sample is pending or being processed is dropped and latches the sticky overrun.
    assign busy      = pending || (state != IDLE);
    assign accept    = sample_ready && !busy;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pending) state_next = PROC;
            PROC:    if (idx == 3'd4) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared rectify + integrate unit, operating on the band selected by idx.
    always_comb begin
        cur_x   = shadow[idx];
        neg_x   = 8'd0 - cur_x;
        acc_cur = acc[idx];
        if (cur_x == 8'h80) begin
            mag = 7'd127;
        end else if (cur_x[7]) begin
            mag = neg_x[6:0];
        end else begin
            mag = cur_x[6:0];
        end
        acc_upd = acc_cur - (acc_cur >> SHIFT) + ({8'd0, mag} << (FRAC - SHIFT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= 1'b0;
            idx       <= 3'd0;
            env_ready <= 1'b0;
            overrun   <= 1'b0;
            env0      <= 8'd0;
            env1      <= 8'd0;
            env2      <= 8'd0;
            env3      <= 8'd0;
            env4      <= 8'd0;
            for (int k = 0; k < 5; k++) begin
                shadow[k] <= 8'd0;
                acc[k]    <= 15'd0;
            end
        end else begin
            env_ready <= (state == DONE);
            if (sample_ready && busy) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                shadow[0] <= band0;
                shadow[1] <= band1;
                shadow[2] <= band2;
                shadow[3] <= band3;
                shadow[4] <= band4;
                pending   <= 1'b1;
            end else if (state == IDLE && pending) begin
                pending <= 1'b0;
                idx     <= 3'd0;
            end
            if (state == PROC) begin
                acc[idx] <= acc_upd;
                idx      <= idx + 3'd1;
            end
            // All five envelopes publish together so consumers never see a mixed set.
            if (state == DONE) begin
                env0 <= {1'b0, acc[0][14:8]};
                env1 <= {1'b0, acc[1][14:8]};
                env2 <= {1'b0, acc[2][14:8]};
                env3 <= {1'b0, acc[3][14:8]};
                env4 <= {1'b0, acc[4][14:8]};
            end
        end
    end

endmodule

// File: tb/tb_band_envelope.sv
// Self-checking bench for band_envelope: a reference integrator model feeds an
// expected-envelope queue that each scenario task pops and compares against the DUT.
module tb_band_envelope;

    localparam int SHIFT = 4;
    localparam int FRAC  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_ready;
    logic [7:0] band0, band1, band2, band3, band4;
    logic [7:0] env0, env1, env2, env3, env4;
    logic       env_ready;
    logic       overrun;
    logic [1:0] state_dbg;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int          acc_m [5];
    logic [39:0] exp_q [$];

    band_envelope #(.SHIFT(SHIFT), .FRAC(FRAC)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_ready (sample_ready),
        .band0        (band0),
        .band1        (band1),
        .band2        (band2),
        .band3        (band3),
        .band4        (band4),
        .env0         (env0),
        .env1         (env1),
        .env2         (env2),
        .env3         (env3),
        .env4         (env4),
        .env_ready    (env_ready),
        .overrun      (overrun),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic int mag_of(input logic [7:0] v);
        int s;
        s = int'($signed(v));
        if (s < 0) s = -s;
        if (s > 127) s = 127;
        return s;
    endfunction

    function automatic logic [39:0] env_bus();
        return {env4, env3, env2, env1, env0};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 5; k++) acc_m[k] = 0;
        exp_q.delete();
    endtask

    task automatic model_push(input logic [39:0] b);
        logic [39:0] e;
        for (int k = 0; k < 5; k++) begin
            acc_m[k] = acc_m[k] - acc_m[k] / (1 << SHIFT) + mag_of(b[8*k +: 8]) * (1 << (FRAC - SHIFT));
            e[8*k +: 8] = 8'(acc_m[k] / 256);
        end
        exp_q.push_back(e);
    endtask

    task automatic drive_bands(input logic [39:0] b);
        {band4, band3, band2, band1, band0} = b;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    // One accepted strobe; lat counts edges after the sampling edge, -1 on timeout.
    task automatic run_strobe(input logic [39:0] b, output logic [39:0] obs, output int lat);
        model_push(b);
        @(posedge clk); #1;
        drive_bands(b);
        sample_ready = 1'b1;
        @(posedge clk); #1;
        sample_ready = 1'b0;
        drive_bands({$urandom, 8'($urandom)});
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (env_ready) begin
                lat = c;
                break;
            end
        end
        obs = env_bus();
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        sample_ready = 1'b0;
        drive_bands({$urandom, 8'($urandom)});
        @(posedge clk); #1;
        total_cnt++;
        if (env_bus() !== 40'd0) $display("FAIL reset_env: got %h expected 0", env_bus());
        else pass_cnt++;
        total_cnt++;
        if (env_ready !== 1'b0) $display("FAIL reset_env_ready: got %b expected 0", env_ready);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun);
        else pass_cnt++;
        total_cnt++;
        if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg);
        else pass_cnt++;
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk); #1;
        total_cnt++;
        if (env_bus() !== 40'd0 || env_ready !== 1'b0)
            $display("FAIL post_reset_idle: got env %h ready %b expected 0/0", env_bus(), env_ready);
        else pass_cnt++;
    endtask

    task automatic test_single();
        logic [39:0] obs, exp_v;
        int lat;
        do_reset();
        run_strobe(40'h00_00_00_00_40, obs, lat);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (lat !== 7) $display("FAIL single_latency: got %0d expected 7", lat);
        else pass_cnt++;
        total_cnt++;
        if (obs !== exp_v) $display("FAIL single_env: got %h expected %h", obs, exp_v);
        else pass_cnt++;
        total_cnt++;
        if (obs !== 40'h00_00_00_00_04) $display("FAIL single_env_abs: got %h expected 0000000004", obs);
        else pass_cnt++;
        total_cnt++;
        if (dut.acc[0] !== 15'd1024) $display("FAIL single_acc0: got %0d expected 1024", dut.acc[0]);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL single_overrun: got %b expected 0", overrun);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (env_ready !== 1'b0) $display("FAIL single_pulse_width: got %b expected 0", env_ready);
        else pass_cnt++;
        repeat (5) @(posedge clk); #1;
        total_cnt++;
        if (env_bus() !== exp_v) $display("FAIL single_hold: got %h expected %h", env_bus(), exp_v);
        else pass_cnt++;
    endtask

    task automatic test_rise();
        logic [39:0] obs, exp_v;
        int lat;
        logic [7:0] prev;
        do_reset();
        prev = 8'd0;
        for (int n = 0; n < 300; n++) begin
            run_strobe(40'h00_00_00_00_40, obs, lat);
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v || lat !== 7)
                $display("FAIL rise_step%0d: got %h lat %0d expected %h lat 7", n, obs, lat, exp_v);
            else pass_cnt++;
            total_cnt++;
            if (obs[7:0] < prev || obs[7:0] > 8'd64)
                $display("FAIL rise_monotonic%0d: got %0d expected %0d..64", n, obs[7:0], prev);
            else pass_cnt++;
            prev = obs[7:0];
            repeat (7) @(posedge clk);
        end
        total_cnt++;
        if (env0 !== 8'd64) $display("FAIL rise_settle: got %0d expected 64", env0);
        else pass_cnt++;
    endtask

    task automatic test_decay();
        logic [39:0] obs, exp_v;
        int lat;
        logic [7:0] prev;
        prev = env0;
        for (int n = 0; n < 300; n++) begin
            run_strobe(40'd0, obs, lat);
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v) $display("FAIL decay_step%0d: got %h expected %h", n, obs, exp_v);
            else pass_cnt++;
            total_cnt++;
            if (obs[7:0] > prev) $display("FAIL decay_monotonic%0d: got %0d expected <= %0d", n, obs[7:0], prev);
            else pass_cnt++;
            prev = obs[7:0];
            repeat (7) @(posedge clk);
        end
        total_cnt++;
        if (env0 !== 8'd0) $display("FAIL decay_final: got %0d expected 0", env0);
        else pass_cnt++;
    endtask

    task automatic test_extremes();
        logic [39:0] obs, exp_v;
        int lat;
        int acc_max;
        do_reset();
        acc_max = 0;
        for (int n = 0; n < 300; n++) begin
            run_strobe({8'h00, 8'hFF, 8'h7F, 8'h80, 8'h00}, obs, lat);
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v) $display("FAIL extreme_step%0d: got %h expected %h", n, obs, exp_v);
            else pass_cnt++;
            for (int k = 0; k < 5; k++) if (int'(dut.acc[k]) > acc_max) acc_max = int'(dut.acc[k]);
            repeat (7) @(posedge clk);
        end
        total_cnt++;
        if (acc_max > 32512) $display("FAIL extreme_acc_bound: got %0d expected <= 32512", acc_max);
        else pass_cnt++;
        total_cnt++;
        if ({env4, env3, env2, env1} !== {8'd0, 8'd1, 8'd127, 8'd127})
            $display("FAIL extreme_settle: got %h expected 00017f7f", {env4, env3, env2, env1});
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        logic [39:0] obs, exp_v;
        int lat;
        do_reset();
        model_push({8'h11, 8'hEC, 8'h7F, 8'h80, 8'h32});
        @(posedge clk); #1;
        drive_bands({8'h11, 8'hEC, 8'h7F, 8'h80, 8'h32});
        sample_ready = 1'b1;
        @(posedge clk); #1;
        sample_ready = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        drive_bands({8'h70, 8'h70, 8'h70, 8'h70, 8'h70});
        sample_ready = 1'b1;
        @(posedge clk); #1;
        sample_ready = 1'b0;
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun);
        else pass_cnt++;
        lat = -1;
        for (int c = 4; c <= 20; c++) begin
            @(posedge clk); #1;
            if (env_ready) begin
                lat = c;
                break;
            end
        end
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (lat !== 7) $display("FAIL overrun_latency: got %0d expected 7", lat);
        else pass_cnt++;
        total_cnt++;
        if (env_bus() !== exp_v) $display("FAIL overrun_env: got %h expected %h", env_bus(), exp_v);
        else pass_cnt++;
        run_strobe(40'h05_05_05_05_05, obs, lat);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (obs !== exp_v || lat !== 7)
            $display("FAIL overrun_next: got %h lat %0d expected %h lat 7", obs, lat, exp_v);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", overrun);
        else pass_cnt++;
        do_reset();
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b expected 0", overrun);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [39:0] exp_v;
        int lat;
        int extra;
        do_reset();
        model_push({8'h9C, 8'h10, 8'hF0, 8'h64, 8'h01});
        @(posedge clk); #1;
        drive_bands({8'h9C, 8'h10, 8'hF0, 8'h64, 8'h01});
        sample_ready = 1'b1;
        @(posedge clk); #1;
        drive_bands(40'h7F_7F_7F_7F_7F);
        @(posedge clk);
        @(posedge clk); #1;
        sample_ready = 1'b0;
        lat = -1;
        for (int c = 3; c <= 20; c++) begin
            @(posedge clk); #1;
            if (env_ready) begin
                lat = c;
                break;
            end
        end
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (lat !== 7) $display("FAIL held_latency: got %0d expected 7", lat);
        else pass_cnt++;
        total_cnt++;
        if (env_bus() !== exp_v) $display("FAIL held_env: got %h expected %h", env_bus(), exp_v);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL held_overrun: got %b expected 1", overrun);
        else pass_cnt++;
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (env_ready) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL held_single_update: got %0d extra pulses expected 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [39:0] obs, exp_v;
        int lat;
        int pulses;
        logic acc_zero;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            run_strobe(40'h00_00_00_00_64, obs, lat);
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v) $display("FAIL mid_preload%0d: got %h expected %h", n, obs, exp_v);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        drive_bands(40'h30_30_30_30_30);
        sample_ready = 1'b1;
        @(posedge clk); #1;
        sample_ready = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        acc_zero = 1'b1;
        for (int k = 0; k < 5; k++) if (dut.acc[k] !== 15'd0) acc_zero = 1'b0;
        total_cnt++;
        if (env_bus() !== 40'd0 || overrun !== 1'b0 || env_ready !== 1'b0)
            $display("FAIL mid_async_outputs: got env %h ovr %b rdy %b expected 0", env_bus(), overrun, env_ready);
        else pass_cnt++;
        total_cnt++;
        if (acc_zero !== 1'b1) $display("FAIL mid_async_acc: got nonzero expected 0");
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (env_ready) pulses++;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL mid_no_pulse: got %0d expected 0", pulses);
        else pass_cnt++;
        run_strobe(40'h00_00_00_00_40, obs, lat);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (obs !== exp_v || lat !== 7 || obs[7:0] !== 8'd4)
            $display("FAIL mid_recover: got %h lat %0d expected %h lat 7", obs, lat, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [39:0] obs, exp_v, b;
        int lat;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            b = {$urandom, 8'($urandom)};
            run_strobe(b, obs, lat);
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs !== exp_v || lat !== 7)
                $display("FAIL random%0d: got %h lat %0d expected %h lat 7", n, obs, lat, exp_v);
            else pass_cnt++;
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
    endtask

    initial begin
        reset        = 1'b1;
        sample_ready = 1'b0;
        drive_bands(40'd0);
        model_clear();
        test_reset();
        test_single();
        test_rise();
        test_decay();
        test_extremes();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/band_envelope.md
Name: band_envelope

Overview:
- Sits directly downstream of the five-band filterbank in the integrated vocoder datapath.
- On each 6 kHz sample strobe, it rectifies the five signed 8-bit band outputs and smooths each through a per-band leaky integrator (exponential moving average).
- A single time-multiplexed arithmetic unit, stepped by a small sequencer, does the work.
- It publishes five unsigned envelope levels plus a one-cycle valid strobe for the synthesis/display stages.

Parameters:
- SHIFT, 4, smoothing exponent; per update the envelope moves 1/2^SHIFT of the way toward the new magnitude; legal range 1..8.
- FRAC, 8, fractional bits held in each accumulator; fixed; SHIFT <= FRAC.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sample_ready  input  1  one-cycle strobe from filterbank: band0..band4 valid this cycle
- band0  input  8  signed band 0 sample
- band1  input  8  signed band 1 sample
- band2  input  8  signed band 2 sample
- band3  input  8  signed band 3 sample
- band4  input  8  signed band 4 sample
- env0  output  8  unsigned envelope, band 0 (bit 7 always 0)
- env1  output  8  unsigned envelope, band 1
- env2  output  8  unsigned envelope, band 2
- env3  output  8  unsigned envelope, band 3
- env4  output  8  unsigned envelope, band 4
- env_ready  output  1  one-cycle strobe: env0..env4 updated this cycle
- overrun  output  1  sticky flag: a sample_ready arrived while busy

Behaviour:
Interface:
- One clock (clk); reset is asynchronous and active-high.

Reset:
- env0..env4 = 0, env_ready = 0, overrun = 0.
- All five accumulators = 0, FSM = IDLE, band index = 0.
- Reset asserted mid-operation aborts the update: no env_ready, no partial output change.

FSM states:
- IDLE:
  - On sample_ready = 1, latch band0..band4 into shadow registers, set index = 0, go to PROC.
- PROC:
  - One band per cycle, index 0..4.
  - Each cycle, update acc[index]; index increments.
  - After index 4, go to DONE.
- DONE:
  - Copy acc[k][14:8] into env k (zero-extended to 8 bits) for all k simultaneously.
  - Pulse env_ready for that cycle; return to IDLE.

Latency and outputs:
- env_ready goes high exactly 7 clk edges after the edge that samples sample_ready (1 capture + 5 PROC + 1 DONE register).
- env outputs change only on that edge; they hold between updates.

Arithmetic, per band:
- mag = |x|, unsigned 7-bit, saturating: -128 -> 127, -1 -> 1, 0 -> 0, 127 -> 127.
- acc is 15-bit unsigned (7 integer . 8 fraction).
- acc_next = acc - (acc >> SHIFT) + (mag << (FRAC - SHIFT)); all shifts logical/floor.
- Invariant: acc <= 127*256; no overflow, no saturation logic needed. Verification asserts acc <= 32512.
- Steady state for constant mag M: env converges exactly to M.

Boundaries:
- sample_ready while in PROC or DONE:
  - The strobe is ignored (sample dropped, shadow registers unchanged).
  - overrun is set to 1 and stays set until reset.
  - The in-flight update completes normally.
- sample_ready in the same cycle as DONE is also dropped and sets overrun.
- A sample_ready held high for multiple cycles counts as one accepted strobe plus an overrun for each busy cycle.
- Input changes on band0..band4 outside sample_ready have no effect.
- Bands are independent: no cross-band state.

Test Plan:
1. Reset, then one sample_ready with band0=64, others 0, SHIFT=4 -> env_ready exactly 7 edges later; acc0 = 1024, env0 = 4, env1..4 = 0, overrun = 0.
2. Hold band0=64 for 300 strobes spaced 16 cycles apart -> env0 rises monotonically and settles at exactly 64, never exceeds 64.
3. band1 = -128, band2 = 127, band3 = -1, band4 = 0 for 300 strobes -> env1 = 127, env2 = 127, env3 = 1, env4 = 0; acc never exceeds 32512.
4. Drive env0 to 64, then band0 = 0 for 300 strobes -> env0 decays monotonically to 0.
5. Second sample_ready 3 cycles after the first -> second sample dropped, overrun = 1 and stays 1; env_ready still at edge 7 with values from the first sample only; overrun clears only on reset.
6. Assert reset during PROC (2 cycles after strobe) -> outputs, accumulators and overrun return to 0 immediately (asynchronous); no env_ready pulse; next strobe after release behaves as in scenario 1.
